// File: rtl/data_memory_interface_if.sv
// Request/response bundle between the memory-access stage (master) and the
// data memory (slave). memory_fault exists only when DMEM_FAULT_EN is defined.
interface data_memory_interface_if;
    logic [31:0] memory_address;
    logic [31:0] memory_data_store;
    logic        memory_read;
    logic [1:0]  memory_write;
    logic [31:0] memory_data_load;
    logic        memory_wait;
`ifdef DMEM_FAULT_EN
    logic        memory_fault;

    modport master (
        output memory_address, memory_data_store, memory_read, memory_write,
        input  memory_data_load, memory_wait, memory_fault
    );

    modport slave (
        input  memory_address, memory_data_store, memory_read, memory_write,
        output memory_data_load, memory_wait, memory_fault
    );
`else
    modport master (
        output memory_address, memory_data_store, memory_read, memory_write,
        input  memory_data_load, memory_wait
    );

    modport slave (
        input  memory_address, memory_data_store, memory_read, memory_write,
        output memory_data_load, memory_wait
    );
`endif
endinterface

// File: rtl/data_memory_interface.sv
// Data-memory slave with programmable wait states. Unaligned accesses are
// split into two word beats (index A, then A+1 modulo DEPTH).
// Optional feature macro: DMEM_FAULT_EN adds memory_fault and blocks
// out-of-range accesses instead of letting them wrap. DEPTH must be >= 2.
module data_memory_interface #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    data_memory_interface_if.slave bus
);

    localparam int         AW = $clog2(DEPTH);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

    logic [31:0] mem [DEPTH];

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   store_q, store_d;
    logic [1:0]    write_q, write_d;
    logic [31:0]   word0_q, word0_d;
    logic [31:0]   load_q, load_d;

    logic          req_active;
    logic [1:0]    offset;
    logic [3:0]    size_mask;
    logic [7:0]    lane_mask;
    logic [63:0]   lane_data;
    logic          is_split;
    logic [AW-1:0] idx_a, idx_b;
    logic [31:0]   rd_a, rd_b;
    logic [63:0]   read_pair;
    logic          access_ok;

    logic          mem_we;
    logic [AW-1:0] mem_idx;
    logic [3:0]    mem_wmask;
    logic [31:0]   mem_wdata;

`ifdef DMEM_FAULT_EN
    logic          range_err_q, range_err_d;
    logic [1:0]    req_span;
    logic [32:0]   req_last;

    // Byte count minus one of the incoming request, for the range check
    always_comb begin
        case (bus.memory_write)
            2'b01:   req_span = 2'd0;
            2'b10:   req_span = 2'd1;
            default: req_span = 2'd3;
        endcase
    end

    assign req_last         = {1'b0, bus.memory_address} + {31'b0, req_span};
    assign access_ok        = !range_err_q;
    assign bus.memory_fault = (state_q == DONE) && range_err_q;
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.memory_address[31:AW+2];
    assign access_ok      = 1'b1;
`endif

    assign req_active = bus.memory_read || (bus.memory_write != 2'b00);
    assign offset     = addr_q[1:0];
    assign idx_a      = addr_q[AW+1:2];
    assign idx_b      = idx_a + AW'(1);
    assign rd_a       = mem[idx_a];
    assign rd_b       = mem[idx_b];
    assign lane_mask  = {4'b0000, size_mask} << offset;
    assign lane_data  = {32'b0, store_q} << {offset, 3'b000};
    assign is_split   = |lane_mask[7:4];
    assign read_pair  = {rd_b, word0_q} >> {offset, 3'b000};

    assign bus.memory_wait      = req_active && (state_q != DONE);
    assign bus.memory_data_load = load_q;

    // Lanes covered by the latched op; reads always cover a full word
    always_comb begin
        case (write_q)
            2'b01:   size_mask = 4'b0001;
            2'b10:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    end

    // Beat sequencing, wait-state countdown and array access requests
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        store_d   = store_q;
        write_d   = write_q;
        word0_d   = word0_q;
        load_d    = load_q;
        mem_we    = 1'b0;
        mem_idx   = idx_a;
        mem_wmask = 4'b0000;
        mem_wdata = lane_data[31:0];
`ifdef DMEM_FAULT_EN
        range_err_d = range_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_active) begin
                    addr_d  = bus.memory_address[AW+1:0];
                    store_d = bus.memory_data_store;
                    write_d = bus.memory_write;
                    cnt_d   = WS;
                    state_d = BEAT0;
`ifdef DMEM_FAULT_EN
                    range_err_d = (req_last >= 33'(DEPTH * 4));
`endif
                end
            end
            BEAT0: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (write_q != 2'b00) begin
                        mem_we    = access_ok;
                        mem_idx   = idx_a;
                        mem_wmask = lane_mask[3:0];
                        mem_wdata = lane_data[31:0];
                    end
                    if (is_split) begin
                        word0_d = rd_a;
                        cnt_d   = WS;
                        state_d = BEAT1;
                    end else begin
                        if (write_q == 2'b00) begin
                            load_d = access_ok ? rd_a : 32'h0;
                        end
                        state_d = DONE;
                    end
                end
            end
            BEAT1: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (write_q != 2'b00) begin
                        mem_we    = access_ok;
                        mem_idx   = idx_b;
                        mem_wmask = lane_mask[7:4];
                        mem_wdata = lane_data[63:32];
                    end else begin
                        load_d = access_ok ? read_pair[31:0] : 32'h0;
                    end
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and data registers; reset aborts any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            store_q <= 32'h0;
            write_q <= 2'b00;
            word0_q <= 32'h0;
            load_q  <= 32'h0;
`ifdef DMEM_FAULT_EN
            range_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            write_q <= write_d;
            word0_q <= word0_d;
            load_q  <= load_d;
`ifdef DMEM_FAULT_EN
            range_err_q <= range_err_d;
`endif
        end
    end

    // Byte-lane array writes; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_wmask[i]) begin
                    mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_interface.sv
// Scoreboard bench for data_memory_interface (DEPTH=1024, WAIT_STATES=1).
// The driver pushes the expected response of each request; the monitor pops
// and compares when the DUT signals completion (request held, wait low).
module tb_data_memory_interface;

    typedef struct {
        logic [31:0] load;
        int          waits;
        logic        fault;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    data_memory_interface_if mem_if();

    data_memory_interface #(
        .DEPTH(1024),
        .WAIT_STATES(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(mem_if)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issue one request, hold it until the DUT completes it, leave it held
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                 input logic rd, input logic [1:0] wr,
                                 input logic [31:0] exp_load, input int exp_waits,
                                 input logic exp_fault);
        exp_t e;
        bit   done;
        e.load  = exp_load;
        e.waits = exp_waits;
        e.fault = exp_fault;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        mem_if.memory_address    = addr;
        mem_if.memory_data_store = data;
        mem_if.memory_read       = rd;
        mem_if.memory_write      = wr;
        done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!mem_if.memory_wait) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL timeout addr 0x%08h: got no completion, expected one within 50 cycles", addr);
        end
    endtask

    task automatic idleCycles(input int n);
        @(posedge clk);
        #1;
        mem_if.memory_read  = 1'b0;
        mem_if.memory_write = 2'b00;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: count wait cycles of the current request, compare at completion
    initial begin
        int   wait_cnt;
        exp_t e;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst || !(mem_if.memory_read || mem_if.memory_write != 2'b00)) begin
                wait_cnt = 0;
            end else if (mem_if.memory_wait) begin
                wait_cnt++;
            end else begin
                if (exp_q.size() == 0) begin
                    checkOutput("sb_expected_entry", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("load_data", mem_if.memory_data_load, e.load);
                    checkOutput("wait_cycles", 32'(wait_cnt), 32'(e.waits));
`ifdef DMEM_FAULT_EN
                    checkOutput("fault", {31'b0, mem_if.memory_fault}, {31'b0, e.fault});
`endif
                end
                wait_cnt = 0;
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not reach the end");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed vectors
    initial begin
        rst = 1'b1;
        mem_if.memory_address    = 32'h0;
        mem_if.memory_data_store = 32'h0;
        mem_if.memory_read       = 1'b0;
        mem_if.memory_write      = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_wait", {31'b0, mem_if.memory_wait}, 32'd0);
        checkOutput("reset_load", mem_if.memory_data_load, 32'h0);
`ifdef DMEM_FAULT_EN
        checkOutput("reset_fault", {31'b0, mem_if.memory_fault}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Aligned word write then read
        applyStimulus(32'h10, 32'hDEADBEEF, 1'b0, 2'b11, 32'h0,        3, 1'b0);
        applyStimulus(32'h10, 32'h0,        1'b1, 2'b00, 32'hDEADBEEF, 3, 1'b0);
        idleCycles(2);
        checkOutput("load_held", mem_if.memory_data_load, 32'hDEADBEEF);

        // Split read across two words (back-to-back requests)
        applyStimulus(32'h20, 32'h11223344, 1'b0, 2'b11, 32'hDEADBEEF, 3, 1'b0);
        applyStimulus(32'h24, 32'h55667788, 1'b0, 2'b11, 32'hDEADBEEF, 3, 1'b0);
        applyStimulus(32'h22, 32'h0,        1'b1, 2'b00, 32'h77881122, 5, 1'b0);

        // Halfword write at offset 3 spills into the next word
        applyStimulus(32'h30, 32'hFFFFFFFF, 1'b0, 2'b11, 32'h77881122, 3, 1'b0);
        applyStimulus(32'h34, 32'hFFFFFFFF, 1'b0, 2'b11, 32'h77881122, 3, 1'b0);
        applyStimulus(32'h33, 32'h0000ABCD, 1'b0, 2'b10, 32'h77881122, 5, 1'b0);
        applyStimulus(32'h30, 32'h0,        1'b1, 2'b00, 32'hCDFFFFFF, 3, 1'b0);
        applyStimulus(32'h34, 32'h0,        1'b1, 2'b00, 32'hFFFFFFAB, 3, 1'b0);

        // Read+write together acts as a byte write; byte at offset 3 never splits
        applyStimulus(32'h40, 32'h0,        1'b0, 2'b11, 32'hFFFFFFAB, 3, 1'b0);
        applyStimulus(32'h41, 32'h1234565A, 1'b1, 2'b01, 32'hFFFFFFAB, 3, 1'b0);
        applyStimulus(32'h40, 32'h0,        1'b1, 2'b00, 32'h00005A00, 3, 1'b0);
        applyStimulus(32'h43, 32'hAAAAAA77, 1'b0, 2'b01, 32'h00005A00, 3, 1'b0);
        applyStimulus(32'h40, 32'h0,        1'b1, 2'b00, 32'h77005A00, 3, 1'b0);

        // Reset during the second beat of a split word write
        applyStimulus(32'h4C, 32'h0,        1'b0, 2'b11, 32'h77005A00, 3, 1'b0);
        applyStimulus(32'h50, 32'h99999999, 1'b0, 2'b11, 32'h77005A00, 3, 1'b0);
        idleCycles(1);
        mem_if.memory_address    = 32'h4E;
        mem_if.memory_data_store = 32'hCAFEF00D;
        mem_if.memory_write      = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        mem_if.memory_write = 2'b00;
        #1;
        checkOutput("abort_wait", {31'b0, mem_if.memory_wait}, 32'd0);
        checkOutput("abort_load", mem_if.memory_data_load, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(32'h50, 32'h0, 1'b1, 2'b00, 32'h99999999, 3, 1'b0);
        applyStimulus(32'h4C, 32'h0, 1'b1, 2'b00, 32'hF00D0000, 3, 1'b0);

`ifdef DMEM_FAULT_EN
        // Out-of-range accesses: no write, zero load, fault in DONE
        applyStimulus(32'hFFC,  32'h12345678, 1'b0, 2'b11, 32'hF00D0000, 3, 1'b0);
        applyStimulus(32'hFFE,  32'hAABBCCDD, 1'b0, 2'b11, 32'hF00D0000, 5, 1'b1);
        applyStimulus(32'hFFC,  32'h0,        1'b1, 2'b00, 32'h12345678, 3, 1'b0);
        applyStimulus(32'h1000, 32'h0,        1'b1, 2'b00, 32'h0,        3, 1'b1);
`else
        // Index wrap from the last word to word 0
        applyStimulus(32'h0,    32'h0,        1'b0, 2'b11, 32'hF00D0000, 3, 1'b0);
        applyStimulus(32'hFFC,  32'h12345678, 1'b0, 2'b11, 32'hF00D0000, 3, 1'b0);
        applyStimulus(32'hFFE,  32'hA1B2C3D4, 1'b0, 2'b11, 32'hF00D0000, 5, 1'b0);
        applyStimulus(32'hFFC,  32'h0,        1'b1, 2'b00, 32'hC3D45678, 3, 1'b0);
        applyStimulus(32'h1000, 32'h0,        1'b1, 2'b00, 32'h0000A1B2, 3, 1'b0);
        applyStimulus(32'hFFE,  32'h0,        1'b1, 2'b00, 32'hA1B2C3D4, 5, 1'b0);
`endif

        idleCycles(2);
        checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
